// File: rtl/ahb_bm_input_hold_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : ahb_bm_input_hold_stage_if
// Description : Master-side AHB and decoder-side signals of the bus-matrix
//               input hold stage, bundled with master/slave views.
// Revision    : 1.0 - initial release
// ============================================================================
interface ahb_bm_input_hold_stage_if #(
    parameter int ADDR_WIDTH  = 32,
    parameter int AUSER_WIDTH = 32
);
    // Master side
    logic                   HSELS;
    logic [ADDR_WIDTH-1:0]  HADDRS;
    logic [1:0]             HTRANSS;
    logic                   HWRITES;
    logic [2:0]             HSIZES;
    logic [2:0]             HBURSTS;
    logic [3:0]             HPROTS;
    logic                   HMASTLOCKS;
    logic [AUSER_WIDTH-1:0] HAUSERS;
    logic                   HREADYS;
    logic                   HREADYOUTS;
    logic [1:0]             HRESPS;

    // Decoder / output-stage side
    logic                   active_in;
    logic                   readyout_in;
    logic [1:0]             resp_in;
    logic                   sel_in;
    logic [ADDR_WIDTH-1:0]  addr_in;
    logic [1:0]             trans_in;
    logic                   write_in;
    logic [2:0]             size_in;
    logic [2:0]             burst_in;
    logic [3:0]             prot_in;
    logic                   mastlock_in;
    logic [AUSER_WIDTH-1:0] auser_in;

    // View of the hold stage itself
    modport slave (
        input  HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS,
               HMASTLOCKS, HAUSERS, HREADYS, active_in, readyout_in, resp_in,
        output HREADYOUTS, HRESPS, sel_in, addr_in, trans_in, write_in,
               size_in, burst_in, prot_in, mastlock_in, auser_in
    );

    // View of whatever drives the stage (master plus decoder model)
    modport master (
        output HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS,
               HMASTLOCKS, HAUSERS, HREADYS, active_in, readyout_in, resp_in,
        input  HREADYOUTS, HRESPS, sel_in, addr_in, trans_in, write_in,
               size_in, burst_in, prot_in, mastlock_in, auser_in
    );
endinterface
`default_nettype wire

// File: rtl/ahb_bm_input_hold_stage.sv
`default_nettype none
// ============================================================================
// Module      : ahb_bm_input_hold_stage
// Description : Bus-matrix slave-interface input stage. Captures an address
//               phase the output stage cannot accept, stalls the master and
//               replays the transfer once granted; otherwise pass-through.
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_bm_input_hold_stage #(
    parameter int ADDR_WIDTH  = 32,
    parameter int AUSER_WIDTH = 32
) (
    input  wire                              HCLK,
    input  wire                              HRESET,
    ahb_bm_input_hold_stage_if.slave         bus
);

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_HOLD = 1'b1;

    logic [0:0]             r_state;
    logic [0:0]             w_state_nxt;
    logic                   w_load;
    logic                   w_live_vld;
    logic                   w_hold_vld;

    logic                   r_hold_sel;
    logic [ADDR_WIDTH-1:0]  r_hold_addr;
    logic [1:0]             r_hold_trans;
    logic                   r_hold_write;
    logic [2:0]             r_hold_size;
    logic [2:0]             r_hold_burst;
    logic [3:0]             r_hold_prot;
    logic                   r_hold_mastlock;
    logic [AUSER_WIDTH-1:0] r_hold_auser;

    assign w_live_vld = bus.HSELS & bus.HTRANSS[1];
    assign w_hold_vld = (r_state == c_ST_HOLD);

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Load is only possible from IDLE, so a stray HREADYS during HOLD is ignored
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (bus.HREADYS && w_live_vld && !bus.active_in) begin
                    w_load      = 1'b1;
                    w_state_nxt = c_ST_HOLD;
                end
            end
            c_ST_HOLD: begin
                if (bus.active_in && bus.readyout_in) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_hold_sel      <= 1'b0;
            r_hold_addr     <= '0;
            r_hold_trans    <= 2'b00;
            r_hold_write    <= 1'b0;
            r_hold_size     <= 3'b000;
            r_hold_burst    <= 3'b000;
            r_hold_prot     <= 4'b0000;
            r_hold_mastlock <= 1'b0;
            r_hold_auser    <= '0;
        end else if (w_load) begin
            r_hold_sel      <= bus.HSELS;
            r_hold_addr     <= bus.HADDRS;
            r_hold_trans    <= bus.HTRANSS;
            r_hold_write    <= bus.HWRITES;
            r_hold_size     <= bus.HSIZES;
            r_hold_burst    <= bus.HBURSTS;
            r_hold_prot     <= bus.HPROTS;
            r_hold_mastlock <= bus.HMASTLOCKS;
            r_hold_auser    <= bus.HAUSERS;
        end
    end

    // Decoder-facing address phase: held copy while stalled, live otherwise
    assign bus.sel_in      = w_hold_vld ? 1'b1            : bus.HSELS;
    assign bus.trans_in    = w_hold_vld ? (r_hold_sel ? r_hold_trans : 2'b00)
                                        : (bus.HSELS  ? bus.HTRANSS  : 2'b00);
    assign bus.addr_in     = w_hold_vld ? r_hold_addr     : bus.HADDRS;
    assign bus.write_in    = w_hold_vld ? r_hold_write    : bus.HWRITES;
    assign bus.size_in     = w_hold_vld ? r_hold_size     : bus.HSIZES;
    assign bus.burst_in    = w_hold_vld ? r_hold_burst    : bus.HBURSTS;
    assign bus.prot_in     = w_hold_vld ? r_hold_prot     : bus.HPROTS;
    assign bus.mastlock_in = w_hold_vld ? r_hold_mastlock : bus.HMASTLOCKS;
    assign bus.auser_in    = w_hold_vld ? r_hold_auser    : bus.HAUSERS;

    // Master-facing response: stall with OKAY while a transfer is parked here
    assign bus.HREADYOUTS  = w_hold_vld ? 1'b0  : bus.readyout_in;
    assign bus.HRESPS      = w_hold_vld ? 2'b00 : bus.resp_in;

endmodule
`default_nettype wire

// File: tb/tb_ahb_bm_input_hold_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahb_bm_input_hold_stage
// Description : Self-checking bench for ahb_bm_input_hold_stage; directed
//               scenarios followed by randomized traffic against a model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_bm_input_hold_stage;

    localparam int ADDR_WIDTH  = 32;
    localparam int AUSER_WIDTH = 32;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  trans;
        logic        write;
        logic [2:0]  size;
        logic [2:0]  burst;
        logic [3:0]  prot;
        logic        lock;
        logic [31:0] auser;
    } xfer_t;

    logic  HCLK;
    logic  HRESET;
    int    n_cmp;
    int    n_mis;
    xfer_t held[$];

    ahb_bm_input_hold_stage_if #(.ADDR_WIDTH(ADDR_WIDTH), .AUSER_WIDTH(AUSER_WIDTH)) bus ();

    ahb_bm_input_hold_stage #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .AUSER_WIDTH (AUSER_WIDTH)
    ) dut (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .bus    (bus)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: at most one parked transfer; response is stalled while one exists
    task automatic check_all(input string tag);
        logic        e_sel, e_wr, e_lk, e_rdy;
        logic [31:0] e_addr, e_au;
        logic [1:0]  e_tr, e_rsp;
        logic [2:0]  e_sz, e_bu;
        logic [3:0]  e_pr;
        if (held.size() != 0) begin
            e_sel = 1'b1;          e_addr = held[0].addr;  e_tr = held[0].trans;
            e_wr  = held[0].write; e_sz   = held[0].size;  e_bu = held[0].burst;
            e_pr  = held[0].prot;  e_lk   = held[0].lock;  e_au = held[0].auser;
            e_rdy = 1'b0;          e_rsp  = 2'b00;
        end else begin
            e_sel = bus.HSELS;     e_addr = bus.HADDRS;
            e_tr  = bus.HSELS ? bus.HTRANSS : 2'b00;
            e_wr  = bus.HWRITES;   e_sz   = bus.HSIZES;    e_bu = bus.HBURSTS;
            e_pr  = bus.HPROTS;    e_lk   = bus.HMASTLOCKS; e_au = bus.HAUSERS;
            e_rdy = bus.readyout_in; e_rsp = bus.resp_in;
        end
        chk({tag, ".sel"},   64'(bus.sel_in),      64'(e_sel));
        chk({tag, ".addr"},  64'(bus.addr_in),     64'(e_addr));
        chk({tag, ".trans"}, 64'(bus.trans_in),    64'(e_tr));
        chk({tag, ".write"}, 64'(bus.write_in),    64'(e_wr));
        chk({tag, ".size"},  64'(bus.size_in),     64'(e_sz));
        chk({tag, ".burst"}, 64'(bus.burst_in),    64'(e_bu));
        chk({tag, ".prot"},  64'(bus.prot_in),     64'(e_pr));
        chk({tag, ".lock"},  64'(bus.mastlock_in), 64'(e_lk));
        chk({tag, ".auser"}, 64'(bus.auser_in),    64'(e_au));
        chk({tag, ".rdy"},   64'(bus.HREADYOUTS),  64'(e_rdy));
        chk({tag, ".resp"},  64'(bus.HRESPS),      64'(e_rsp));
    endtask

    task automatic model_edge();
        xfer_t x;
        if (HRESET) begin
            held.delete();
        end else if (held.size() != 0) begin
            if (bus.active_in && bus.readyout_in) held.delete();
        end else if (bus.HREADYS && bus.HSELS && bus.HTRANSS[1] && !bus.active_in) begin
            x.addr = bus.HADDRS;   x.trans = bus.HTRANSS; x.write = bus.HWRITES;
            x.size = bus.HSIZES;   x.burst = bus.HBURSTS; x.prot  = bus.HPROTS;
            x.lock = bus.HMASTLOCKS; x.auser = bus.HAUSERS;
            held.push_back(x);
        end
    endtask

    task automatic step();
        @(posedge HCLK);
        model_edge();
        #1;
    endtask

    task automatic drive(input logic sel, input logic [1:0] tr, input logic [31:0] addr,
                         input logic wr, input logic rdy_s, input logic act,
                         input logic rdy_o, input logic [1:0] rsp);
        bus.HSELS = sel;   bus.HTRANSS = tr;     bus.HADDRS = addr;  bus.HWRITES = wr;
        bus.HREADYS = rdy_s; bus.active_in = act; bus.readyout_in = rdy_o; bus.resp_in = rsp;
        bus.HSIZES = 3'($urandom); bus.HBURSTS = 3'($urandom); bus.HPROTS = 4'($urandom);
        bus.HMASTLOCKS = 1'($urandom); bus.HAUSERS = $urandom;
    endtask

    initial begin
        n_cmp = 0;
        n_mis = 0;
        HRESET = 1'b1;
        drive(1'b0, 2'b00, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00);
        #2;
        held.delete();
        chk("rst.sel",   64'(bus.sel_in),     64'd0);
        chk("rst.trans", 64'(bus.trans_in),   64'd0);
        chk("rst.rdy",   64'(bus.HREADYOUTS), 64'd1);
        chk("rst.resp",  64'(bus.HRESPS),     64'd0);
        step();
        step();
        HRESET = 1'b0;

        // Granted NONSEQ read passes straight through
        drive(1'b1, 2'b10, 32'h4000_0010, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00);
        #1;
        chk("pass.addr", 64'(bus.addr_in),    64'h4000_0010);
        chk("pass.rdy0", 64'(bus.HREADYOUTS), 64'd0);
        bus.readyout_in = 1'b1;
        #1;
        chk("pass.rdy1", 64'(bus.HREADYOUTS), 64'd1);
        check_all("pass");

        // Ungranted NONSEQ write is parked; data phase response masked
        step();
        drive(1'b1, 2'b10, 32'h8000_0004, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00);
        #1;
        check_all("load");
        step();
        drive(1'b1, 2'b11, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01);
        #1;
        chk("hold.addr",  64'(bus.addr_in),    64'h8000_0004);
        chk("hold.write", 64'(bus.write_in),   64'd1);
        chk("hold.rdy",   64'(bus.HREADYOUTS), 64'd0);
        chk("hold.resp",  64'(bus.HRESPS),     64'd0);
        chk("hold.trans", 64'(bus.trans_in),   64'h2);
        check_all("hold");
        bus.active_in = 1'b1;
        step();
        drive(1'b1, 2'b00, 32'h0000_0abc, 1'b0, 1'b1, 1'b1, 1'b1, 2'b01);
        #1;
        chk("rel.rdy",  64'(bus.HREADYOUTS), 64'd1);
        chk("rel.resp", 64'(bus.HRESPS),     64'h1);
        chk("rel.addr", 64'(bus.addr_in),    64'h0000_0abc);
        check_all("rel");

        // IDLE transfer and unselected NONSEQ never park
        drive(1'b1, 2'b00, 32'h5000_0000, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00);
        step();
        #1;
        chk("idle.rdy", 64'(bus.HREADYOUTS), 64'd1);
        drive(1'b0, 2'b10, 32'h5000_0004, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00);
        #1;
        chk("unsel.trans", 64'(bus.trans_in), 64'd0);
        step();
        #1;
        chk("unsel.rdy", 64'(bus.HREADYOUTS), 64'd1);
        check_all("unsel");

        // Asynchronous reset drops a parked transfer immediately
        drive(1'b1, 2'b10, 32'h2000_0000, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00);
        step();
        drive(1'b1, 2'b10, 32'h3000_0008, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
        #1;
        chk("prerst.addr", 64'(bus.addr_in), 64'h2000_0000);
        HRESET = 1'b1;
        held.delete();
        #1;
        chk("arst.addr", 64'(bus.addr_in),    64'h3000_0008);
        chk("arst.rdy",  64'(bus.HREADYOUTS), 64'd1);
        check_all("arst");
        step();
        HRESET = 1'b0;

        // Randomized traffic with occasional mid-cycle resets
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 3) != 0), 2'($urandom),
                  (($urandom_range(0, 1) != 0) ? $urandom : 32'(i)),
                  1'($urandom), ($urandom_range(0, 4) != 0),
                  1'($urandom), ($urandom_range(0, 3) != 0), 2'($urandom));
            #1;
            check_all("rnd");
            if ($urandom_range(0, 63) == 0) begin
                HRESET = 1'b1;
                held.delete();
                #1;
                check_all("rnd.rst");
            end
            step();
            HRESET = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
